// File: rtl/fb_pattern_gen.sv
// rtl/fb_pattern_gen.sv - paced framebuffer test-pattern generator with a moving block
module fb_pattern_gen #(
  parameter int WIDTH             = 640,
  parameter int HEIGHT            = 480,
  parameter int COLOR_BITS        = 18,
  parameter int CYCLES_PER_PIXEL  = 4,
  parameter int BLOCK_PX          = 32,
  parameter int BLOCK_STEP        = 8,
  parameter int COLOR_STEP_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  ddr_rst,
  input  logic                  enable,
  input  logic                  auto_mode,
  input  logic [2:0]            pattern_sel,
  input  logic                  fb_ready,
  output logic                  fb_we,
  output logic [COLOR_BITS-1:0] fb_data,
  output logic                  fb_vsync,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            pattern
);

  localparam int C  = COLOR_BITS / 3;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(CYCLES_PER_PIXEL);

  localparam logic [CW-1:0] CNT_LOAD = CW'(CYCLES_PER_PIXEL - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [C-1:0]  BG_B0    = {1'b1, {(C-1){1'b0}}};

  typedef enum logic {S_WAIT, S_ISSUE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]   x, block_x, block_x_nxt;
  logic [YW-1:0]   y, block_y, block_y_nxt;
  logic            block_wrap;
  logic [2:0]      pattern_nxt;
  logic [C-1:0]    bg_r, bg_g, bg_b;
  logic [C-1:0]    pix_r, pix_g, pix_b;
  logic [2:0]      bar_idx;
  logic            in_block;
  logic            xfer, frame_end, bg_step;

  assign fb_we     = (state == S_ISSUE);
  assign xfer      = fb_we & fb_ready;
  assign frame_end = xfer && (x == X_LAST) && (y == Y_LAST);
  assign bg_step   = (frame_cnt & 16'(COLOR_STEP_FRAMES - 1)) == 16'd0;
  assign fb_data   = {pix_r, pix_g, pix_b};

  // Pacing FSM state register
  always_ff @(posedge clk) begin
    if (ddr_rst) begin
      state <= S_WAIT;
      cnt   <= CNT_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Countdown in WAIT; entering ISSUE on the 1->0 step keeps the period at exactly CYCLES_PER_PIXEL
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == '0) begin
          if (enable) state_nxt = S_ISSUE;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CW'(1) && enable) state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fb_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Next block position; the row wrap test uses the already-advanced row
  always_comb begin
    block_x_nxt = block_x;
    block_y_nxt = block_y;
    block_wrap  = 1'b0;
    if (32'(block_x) + 32'(BLOCK_STEP) > 32'(WIDTH - BLOCK_PX)) begin
      block_x_nxt = '0;
      if (32'(block_y) + 32'(2 * BLOCK_PX) > 32'(HEIGHT - BLOCK_PX)) begin
        block_y_nxt = '0;
        block_wrap  = 1'b1;
      end else begin
        block_y_nxt = block_y + YW'(BLOCK_PX);
      end
    end else begin
      block_x_nxt = block_x + XW'(BLOCK_STEP);
    end
  end

  // Pattern chosen for the next frame
  always_comb begin
    pattern_nxt = pattern;
    if (auto_mode) begin
      if (block_wrap) pattern_nxt = (pattern >= 3'd3) ? 3'd0 : pattern + 3'd1;
    end else begin
      pattern_nxt = pattern_sel;
    end
  end

  // Raster position plus all per-frame state, which only changes at frame end
  always_ff @(posedge clk) begin
    if (ddr_rst) begin
      x         <= '0;
      y         <= '0;
      fb_vsync  <= 1'b0;
      frame_cnt <= 16'd0;
      pattern   <= 3'd0;
      block_x   <= '0;
      block_y   <= '0;
      bg_r      <= '0;
      bg_g      <= '1;
      bg_b      <= BG_B0;
    end else begin
      fb_vsync <= frame_end;
      if (xfer) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
        block_x   <= block_x_nxt;
        block_y   <= block_y_nxt;
        pattern   <= pattern_nxt;
        if (bg_step) begin
          bg_r <= bg_r + C'(1);
          bg_g <= bg_g + C'(2);
          bg_b <= bg_b + C'(3);
        end
      end
    end
  end

  // Pixel colour from position; the block overrides every pattern
  always_comb begin
    pix_r    = '0;
    pix_g    = '0;
    pix_b    = '0;
    bar_idx  = 3'((32'(x) * 32'd8) / 32'(WIDTH));
    in_block = (32'(x) >= 32'(block_x)) && (32'(x) < 32'(block_x) + 32'(BLOCK_PX)) &&
               (32'(y) >= 32'(block_y)) && (32'(y) < 32'(block_y) + 32'(BLOCK_PX));
    if (in_block) begin
      pix_g = '1;
    end else begin
      case (pattern)
        3'd1: begin
          pix_r = C'(32'(x) >> 3);
          pix_g = C'(32'(y) >> 3);
          pix_b = pix_r + pix_g;
        end
        3'd2: begin
          pix_r = bg_r;
          pix_g = bg_g;
          pix_b = bg_b;
        end
        3'd3: begin
          pix_r = {C{bar_idx[2]}};
          pix_g = {C{bar_idx[1]}};
          pix_b = {C{bar_idx[0]}};
        end
        default: begin
          if (x[3:0] == 4'd0 || y[3:0] == 4'd0) begin
            pix_r = '1;
            pix_g = '1;
            pix_b = '1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pattern_gen.sv
// tb/tb_fb_pattern_gen.sv - self-checking bench for fb_pattern_gen
module tb_fb_pattern_gen;

  localparam int W    = 16;
  localparam int H    = 16;
  localparam int CPP  = 4;
  localparam int PX   = 4;
  localparam int STEP = 4;
  localparam int CSF  = 8;

  logic        clk = 1'b0;
  logic        ddr_rst, enable, auto_mode, fb_ready;
  logic [2:0]  pattern_sel;
  logic        fb_we, fb_vsync;
  logic [17:0] fb_data;
  logic [15:0] frame_cnt;
  logic [2:0]  pattern;

  fb_pattern_gen #(
    .WIDTH(W), .HEIGHT(H), .COLOR_BITS(18), .CYCLES_PER_PIXEL(CPP),
    .BLOCK_PX(PX), .BLOCK_STEP(STEP), .COLOR_STEP_FRAMES(CSF)
  ) dut (
    .clk(clk), .ddr_rst(ddr_rst), .enable(enable), .auto_mode(auto_mode),
    .pattern_sel(pattern_sel), .fb_ready(fb_ready), .fb_we(fb_we), .fb_data(fb_data),
    .fb_vsync(fb_vsync), .frame_cnt(frame_cnt), .pattern(pattern)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model of what the generator should be doing
  int mx, my, bx, by, pat, bgr, bgg, bgb, fcnt, fdone;
  int gap;
  bit en_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic int exp_pixel(input int px, input int py);
    int r, g, b, i;
    if (px >= bx && px < bx + PX && py >= by && py < by + PX) return 63 * 64;
    case (pat)
      1: begin r = (px / 8) % 64; g = (py / 8) % 64; b = (r + g) % 64; end
      2: begin r = bgr; g = bgg; b = bgb; end
      3: begin
        i = px * 8 / W;
        r = ((i / 4) % 2) ? 63 : 0;
        g = ((i / 2) % 2) ? 63 : 0;
        b = (i % 2) ? 63 : 0;
      end
      default: begin
        r = (px % 16 == 0 || py % 16 == 0) ? 63 : 0;
        g = r;
        b = r;
      end
    endcase
    return r * 4096 + g * 64 + b;
  endfunction

  task automatic model_frame_end();
    bit wrap;
    wrap = 0;
    if (fcnt % CSF == 0) begin
      bgr = (bgr + 1) % 64;
      bgg = (bgg + 2) % 64;
      bgb = (bgb + 3) % 64;
    end
    fcnt  = (fcnt + 1) % 65536;
    fdone = fdone + 1;
    if (bx + STEP > W - PX) begin
      bx = 0;
      by = by + PX;
      if (by + PX > H - PX) begin by = 0; wrap = 1; end
    end else begin
      bx = bx + STEP;
    end
    if (auto_mode) begin
      if (wrap) pat = (pat > 3) ? 0 : (pat + 1) % 4;
    end else begin
      pat = pattern_sel;
    end
  endtask

  task automatic do_reset();
    ddr_rst = 1'b1;
    enable  = 1'b1;
    @(posedge clk); #1;
    ddr_rst = 1'b0;
    mx = 0; my = 0; bx = 0; by = 0; pat = 0;
    bgr = 0; bgg = 63; bgb = 32; fcnt = 0;
    gap = 1; en_all = 1;
    chk("rst_we", fb_we, 0);
    chk("rst_vsync", fb_vsync, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_pattern", pattern, 0);
  endtask

  // one clock: drive ready, check the pixel being offered, advance, check outputs
  task automatic step(input bit rdy);
    bit pre_we, xfer, stall, last;
    logic [17:0] pd;
    fb_ready = rdy;
    pre_we = fb_we;
    xfer   = fb_we && rdy;
    stall  = fb_we && !rdy;
    pd     = fb_data;
    if (!enable) en_all = 0;
    last = xfer && mx == W - 1 && my == H - 1;
    if (xfer) chk("pixel", fb_data, exp_pixel(mx, my));
    @(posedge clk); #1;
    if (xfer) begin
      mx = mx + 1;
      if (mx == W) begin mx = 0; my = (my + 1) % H; end
      if (last) model_frame_end();
      gap = 0;
      en_all = 1;
    end
    chk("vsync", fb_vsync, 32'(last));
    chk("frame_cnt", frame_cnt, fcnt);
    chk("pattern", pattern, pat);
    if (stall) begin
      chk("stall_we", fb_we, 1);
      chk("stall_data", fb_data, pd);
    end
    if (!fb_we) gap++;
    else if (!pre_we && en_all) chk("pace", gap, CPP - 1);
  endtask

  task automatic goto_pixel(input int tx, input int ty);
    int budget;
    budget = 20000;
    while (!(fb_we && mx == tx && my == ty) && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) timeout_fail("goto_pixel");
  endtask

  task automatic run_frames(input int n, input int rdy_pct, input bit rand_en);
    int target, budget;
    target = fdone + n;
    budget = n * 3000 + 1000;
    while (fdone < target && budget > 0) begin
      enable = rand_en ? ($urandom_range(9, 0) != 0) : 1'b1;
      step($urandom_range(99, 0) < rdy_pct);
      budget--;
    end
    enable = 1'b1;
    if (fdone < target) timeout_fail("run_frames");
  endtask

  task automatic first_we_latency(input string tag);
    int n;
    n = 0;
    while (!fb_we && n < 20) begin step(1); n++; end
    chk(tag, n, CPP - 1);
  endtask

  initial begin
    int yo;
    ddr_rst = 1'b1; enable = 1'b1; auto_mode = 1'b1; pattern_sel = 3'd0; fb_ready = 1'b1;
    fdone = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // clean first frame, then auto-cycling with random stalls and enable gaps
    first_we_latency("first_we_latency");
    run_frames(1, 100, 0);
    chk("frame1_cnt", frame_cnt, 1);
    run_frames(11, 80, 1);
    chk("auto_wrap_pattern", pattern, 1);
    run_frames(1, 80, 1);

    // directed 10-cycle stall, then manual pattern switch mid-frame
    goto_pixel(5, 5);
    repeat (10) step(0);
    step(1);
    first_we_latency("post_stall_gap");
    auto_mode = 1'b0;
    pattern_sel = 3'd3;
    run_frames(1, 90, 0);
    chk("manual_pattern", pattern, 3);
    yo = (by + 8) % H;
    goto_pixel(2, yo);
    chk("bars_x2", fb_data, 18'h0003F);
    step(1);
    goto_pixel(14, yo);
    chk("bars_x14", fb_data, 18'h3FFFF);
    step(1);

    // background colour stepping in SOLID
    pattern_sel = 3'd2;
    do_reset();
    run_frames(8, 100, 0);
    goto_pixel(15, 15);
    chk("solid_bg_8frames", fb_data, 18'h01063);
    step(1);

    // reset in the middle of a stall
    goto_pixel(7, 9);
    repeat (4) step(0);
    fb_ready = 1'b0;
    do_reset();
    fb_ready = 1'b1;
    first_we_latency("rst_first_we_latency");
    chk("rst_first_pixel", fb_data, 18'h00FC0);
    run_frames(1, 70, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
